// File: rtl/ap_add_sequencer.sv
// Bit-serial associative adder controller: computes B <= A + B in place across all CAM rows at once.
// Latency: CLR + 8*OP_W compare/write cycles + DONE, so 2+8*OP_W cycles from the accepted start. There is no backpressure; start is ignored while busy.
module ap_add_sequencer #(
   parameter int N_ROWS        = 8,
   parameter int OP_W          = 4,
   parameter int RAM_ADDR_BITS = 1
) (
   input  logic                     clka,
   input  logic                     rst,
   input  logic                     start,
   input  logic [RAM_ADDR_BITS-1:0] row_addr,
   output logic                     busy,
   output logic                     done,
   output logic [RAM_ADDR_BITS-1:0] cam_addr,
   output logic [2*OP_W:0]          cam_key,
   output logic [2*OP_W:0]          cam_mask,
   output logic [2*OP_W:0]          cam_dina,
   output logic [N_ROWS-1:0]        cam_wea,
   input  logic [N_ROWS-1:0]        cam_match,
   output logic [N_ROWS-1:0]        tag
);
   localparam int WORD_W = 2*OP_W + 1;
   localparam int C_POS  = 2*OP_W;
   localparam int BIT_W  = (OP_W > 1) ? $clog2(OP_W) : 1;

   typedef enum logic [2:0] {IDLE, CLR, CMP, WR, DONE} state_t;

   state_t           state, state_nxt;
   logic [BIT_W-1:0] bit_cnt;
   logic [1:0]       pass_cnt;
   logic             last_step;
   logic [2:0]       pat_key;
   logic [1:0]       pat_new;
   logic [WORD_W-1:0] c_m, b_m, a_m;

   assign last_step = (pass_cnt == 2'd3) && (bit_cnt == BIT_W'(OP_W-1));

   always_ff @(posedge clka) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CLR;
         CLR:     state_nxt = CMP;
         CMP:     state_nxt = WR;
         WR:      state_nxt = last_step ? DONE : CMP;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         bit_cnt  <= '0;
         pass_cnt <= '0;
         tag      <= '0;
         cam_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               bit_cnt  <= '0;
               pass_cnt <= '0;
               if (start) cam_addr <= row_addr;
            end
            CMP: tag <= cam_match;
            WR: if (!last_step) begin
               pass_cnt <= pass_cnt + 2'd1;
               if (pass_cnt == 2'd3) bit_cnt <= bit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Pass order keeps any rewritten row from matching a later pattern in the same bit.
   always_comb begin
      pat_key = 3'b011;
      pat_new = 2'b10;
      case (pass_cnt)
         2'd0: begin pat_key = 3'b011; pat_new = 2'b10; end
         2'd1: begin pat_key = 3'b001; pat_new = 2'b01; end
         2'd2: begin pat_key = 3'b100; pat_new = 2'b01; end
         2'd3: begin pat_key = 3'b110; pat_new = 2'b10; end
         default: ;
      endcase
   end

   assign c_m = WORD_W'(1) << C_POS;
   assign b_m = WORD_W'(1) << (OP_W + int'(bit_cnt));
   assign a_m = WORD_W'(1) << bit_cnt;

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      cam_key  = '0;
      cam_mask = '0;
      cam_dina = '0;
      cam_wea  = '0;
      case (state)
         CLR: begin
            busy     = 1'b1;
            cam_mask = c_m;
            cam_wea  = '1;
         end
         CMP: begin
            busy     = 1'b1;
            cam_mask = c_m | b_m | a_m;
            cam_key  = ({WORD_W{pat_key[2]}} & c_m) | ({WORD_W{pat_key[1]}} & b_m)
                     | ({WORD_W{pat_key[0]}} & a_m);
         end
         WR: begin
            busy     = 1'b1;
            cam_mask = c_m | b_m;
            cam_dina = ({WORD_W{pat_new[1]}} & c_m) | ({WORD_W{pat_new[0]}} & b_m);
            cam_wea  = tag;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end
endmodule
